// File: rtl/pipelined_multiplier.sv
// Three-stage radix-4 Booth / Wallace-tree multiplier with per-operand signedness and a tag.
// Optional pipeline kill input is built when MUL_FLUSH_EN is defined.
module pipelined_multiplier #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned TAG_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   a_rst,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic                   a_signed_i,
   input  logic                   b_signed_i,
   input  logic [WIDTH-1:0]       a_i,
   input  logic [WIDTH-1:0]       b_i,
   input  logic [TAG_WIDTH-1:0]   tag_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [2*WIDTH-1:0]     res_o,
   output logic [TAG_WIDTH-1:0]   tag_o
`ifdef MUL_FLUSH_EN
   ,
   input  logic                   flush_i
`endif
);

   localparam int unsigned PW  = 2*WIDTH + 4;
   localparam int unsigned BW  = WIDTH + 2;
   localparam int unsigned NPP = BW / 2;

   logic v1, v2, v3;
   logic load1, load2, load3;
   logic flush;

`ifdef MUL_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   assign load3      = v2 & (~v3 | out_ready_i);
   assign load2      = v1 & (~v2 | load3);
   assign in_ready_o = (~v1 | load2) & ~flush;
   assign load1      = in_valid_i & in_ready_o;

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (flush) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         v1 <= load1 | (v1 & ~load2);
         v2 <= load2 | (v2 & ~load3);
         v3 <= load3 | (v3 & ~out_ready_i);
      end
   end

   // Stage 1: Booth recoding; b gets an implicit 0 below its LSB
   logic [PW-1:0]  a_ext;
   logic [BW:0]    b_ext;
   logic [2:0]     digit;
   logic [PW-1:0]  mag;
   logic [PW-1:0]  pp     [NPP];
   logic [NPP-1:0] neg;

   assign a_ext = a_signed_i ? {{(WIDTH+4){a_i[WIDTH-1]}}, a_i} : {{(WIDTH+4){1'b0}}, a_i};
   assign b_ext = {(b_signed_i ? {2{b_i[WIDTH-1]}} : 2'b00), b_i, 1'b0};

   // Negative digits are stored as ~mag; the +1 is kept as a separate carry at column 2i
   always_comb begin
      digit = '0;
      mag   = '0;
      neg   = '0;
      for (int unsigned i = 0; i < NPP; i++) begin
         digit = b_ext[2*i +: 3];
         case (digit)
            3'b001, 3'b010, 3'b101, 3'b110: mag = a_ext;
            3'b011, 3'b100:                 mag = a_ext << 1;
            default:                        mag = '0;
         endcase
         neg[i] = digit[2];
         pp[i]  = (digit[2] ? ~mag : mag) << (2*i);
      end
   end

   logic [PW-1:0]        pp_q  [NPP];
   logic [NPP-1:0]       neg_q;
   logic [TAG_WIDTH-1:0] tag1_q;

   always_ff @(posedge clk) begin
      if (load1) begin
         for (int unsigned i = 0; i < NPP; i++) pp_q[i] <= pp[i];
         neg_q  <= neg;
         tag1_q <= tag_i;
      end
   end

   // Stage 2: Wallace reduction, 3:2 compressors per level until two rows remain
   logic [PW-1:0] cur [NPP];
   logic [PW-1:0] nxt [NPP];
   int unsigned   cnt, nc;
   logic [PW-1:0] sum_d, carry_d, negv_d;

   always_comb begin
      for (int unsigned i = 0; i < NPP; i++) cur[i] = pp_q[i];
      cnt = NPP;
      nc  = 0;
      nxt = cur;
      for (int unsigned l = 0; l < NPP; l++) begin
         nxt = cur;
         nc  = 0;
         for (int unsigned j = 0; j < NPP; j += 3) begin
            if (j + 2 < cnt) begin
               nxt[nc]     = cur[j] ^ cur[j+1] ^ cur[j+2];
               nxt[nc + 1] = ((cur[j] & cur[j+1]) | (cur[j] & cur[j+2]) | (cur[j+1] & cur[j+2])) << 1;
               nc = nc + 2;
            end else if (j < cnt) begin
               nxt[nc] = cur[j];
               nc = nc + 1;
               if (j + 1 < cnt) begin
                  nxt[nc] = cur[j+1];
                  nc = nc + 1;
               end
            end
         end
         if (cnt > 2) begin
            cur = nxt;
            cnt = nc;
         end
      end
      sum_d   = cur[0];
      carry_d = (cnt > 1) ? cur[1] : '0;
      negv_d  = '0;
      for (int unsigned i = 0; i < NPP; i++) negv_d[2*i] = neg_q[i];
   end

   logic [PW-1:0]        sum_q, carry_q, negv_q;
   logic [TAG_WIDTH-1:0] tag2_q;

   always_ff @(posedge clk) begin
      if (load2) begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         negv_q  <= negv_d;
         tag2_q  <= tag1_q;
      end
   end

   // Stage 3: carry-propagate add, product taken modulo 2^(2*WIDTH)
   logic [PW-1:0] res_full;
   logic          unused_hi;

   assign res_full  = sum_q + carry_q + negv_q;
   assign unused_hi = ^res_full[PW-1:2*WIDTH];

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         res_o <= '0;
         tag_o <= '0;
      end else if (load3) begin
         res_o <= res_full[2*WIDTH-1:0];
         tag_o <= tag2_q;
      end
   end

   assign out_valid_o = v3;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Self-checking bench for pipelined_multiplier: directed vectors, corner sequences and a
// randomized scoreboard against a plain-arithmetic product model.
module tb_pipelined_multiplier;

   localparam int unsigned W  = 32;
   localparam int unsigned TW = 4;

   logic          clk = 1'b0;
   logic          a_rst = 1'b1;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic          a_signed_i = 1'b0;
   logic          b_signed_i = 1'b0;
   logic [W-1:0]  a_i = '0;
   logic [W-1:0]  b_i = '0;
   logic [TW-1:0] tag_i = '0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b1;
   logic [2*W-1:0] res_o;
   logic [TW-1:0] tag_o;
`ifdef MUL_FLUSH_EN
   logic          flush_i = 1'b0;
`endif

   pipelined_multiplier #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
      .clk         (clk),
      .a_rst       (a_rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_signed_i  (a_signed_i),
      .b_signed_i  (b_signed_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .tag_i       (tag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .res_o       (res_o),
      .tag_o       (tag_o)
`ifdef MUL_FLUSH_EN
      ,
      .flush_i     (flush_i)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [2*W-1:0] exp_res[$];
   logic [TW-1:0]  exp_tag[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Product of the operands after extension, reduced modulo 2^(2W)
   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sa, input logic sb);
      logic [2*W-1:0] ea, eb;
      ea = sa ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      eb = sb ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ea * eb;
   endfunction

   task automatic rand_op();
      in_valid_i = 1'b1;
      a_i        = $urandom;
      b_i        = $urandom;
      a_signed_i = 1'($urandom_range(0, 1));
      b_signed_i = 1'($urandom_range(0, 1));
      tag_i      = TW'($urandom);
      if ($urandom_range(0, 7) == 0) a_i = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b_i = 32'hFFFF_FFFF;
   endtask

   // Scoreboard: records accepts and checks every drained result in order
   logic           held_prev = 1'b0;
   logic [2*W-1:0] held_res;
   logic [TW-1:0]  held_tag;

   initial begin
      logic [2*W-1:0] r;
      logic [TW-1:0]  t;
      forever begin
         @(negedge clk); #1;
         if (a_rst) begin
            held_prev = 1'b0;
         end else begin
            if (held_prev && out_valid_o) begin
               chk("hold_res", 64'(res_o), 64'(held_res));
               chk("hold_tag", 64'(tag_o), 64'(held_tag));
            end
            held_prev = out_valid_o && !out_ready_i;
            held_res  = res_o;
            held_tag  = tag_o;
            if (in_valid_i && in_ready_o) begin
               exp_res.push_back(model(a_i, b_i, a_signed_i, b_signed_i));
               exp_tag.push_back(tag_i);
            end
            if (out_valid_o && out_ready_i) begin
               if (exp_res.size() == 0) begin
                  chk("unexpected_result", 64'(out_valid_o), 64'd0);
               end else begin
                  r = exp_res.pop_front();
                  t = exp_tag.pop_front();
                  chk("sb_res", 64'(res_o), 64'(r));
                  chk("sb_tag", 64'(tag_o), 64'(t));
               end
            end
         end
      end
   end

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           sa;
      logic           sb;
      logic [TW-1:0]  tag;
      logic [2*W-1:0] res;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat, acc, dr;
      logic [2*W-1:0] hold;

      vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd3,  64'hFFFF_FFFE_0000_0001};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd5,  64'h0000_0000_0000_0001};
      vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd7,  64'h4000_0000_0000_0000};
      vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd9,  64'hFFFF_FFFF_0000_0001};
      vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd2,  64'h8000_0000_8000_0000};
      vecs[5] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1'b1, 4'd12, 64'hFFFF_FFFF_FFFF_FFEB};
      vecs[6] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, 4'd15, 64'h0000_0000_0000_0000};
      vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'd1,  64'h4000_0000_0000_0000};

      // Reset state
      @(negedge clk); #1;
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_res",   64'(res_o),       64'd0);
      chk("rst_tag",   64'(tag_o),       64'd0);
      @(negedge clk);
      a_rst = 1'b0;
      #1;
      chk("ready_after_rst", 64'(in_ready_o), 64'd1);

      // Directed vectors, one op at a time
      for (int unsigned k = 0; k < 8; k++) begin
         @(negedge clk);
         in_valid_i = 1'b1; a_i = vecs[k].a; b_i = vecs[k].b;
         a_signed_i = vecs[k].sa; b_signed_i = vecs[k].sb; tag_i = vecs[k].tag;
         out_ready_i = 1'b1;
         #1;
         chk("tbl_accept", 64'(in_ready_o), 64'd1);
         lat = 0;
         do begin
            @(negedge clk); in_valid_i = 1'b0; #1; lat++;
         end while (!out_valid_o && lat < 8);
         chk("tbl_latency", 64'(lat), 64'd3);
         chk("tbl_res", 64'(res_o), 64'(vecs[k].res));
         chk("tbl_tag", 64'(tag_o), 64'(vecs[k].tag));
      end

      // Streaming: 8 back-to-back ops, results in cycles 3..10
      @(negedge clk); #1;
      for (int cyc = 0; cyc < 13; cyc++) begin
         @(negedge clk);
         if (cyc < 8) rand_op(); else in_valid_i = 1'b0;
         #1;
         if (cyc < 8) chk("stream_ready", 64'(in_ready_o), 64'd1);
         chk("stream_valid", 64'(out_valid_o), 64'((cyc >= 3 && cyc <= 10) ? 1 : 0));
      end

      // Backpressure: exactly 3 accepted, output held, pass-through ready on release
      out_ready_i = 1'b0;
      acc = 0;
      hold = '0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         rand_op();
         #1;
         if (in_valid_i && in_ready_o) acc++;
         if (cyc == 3) hold = res_o;
         if (cyc > 3) chk("bp_hold", 64'(res_o), 64'(hold));
      end
      chk("bp_accepts", 64'(acc), 64'd3);
      chk("bp_ready_low", 64'(in_ready_o), 64'd0);
      @(negedge clk);
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      #1;
      chk("bp_ready_passthru", 64'(in_ready_o), 64'd1);
      dr = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (cyc > 0) begin @(negedge clk); #1; end
         if (out_valid_o && out_ready_i) dr++;
      end
      chk("bp_drained", 64'(dr), 64'd3);

      // Reset with two ops in flight
      @(negedge clk); rand_op();
      @(negedge clk); rand_op();
      @(negedge clk);
      in_valid_i = 1'b0;
      a_rst = 1'b1;
      exp_res.delete();
      exp_tag.delete();
      #1;
      chk("midrst_valid", 64'(out_valid_o), 64'd0);
      chk("midrst_res",   64'(res_o),       64'd0);
      @(negedge clk);
      a_rst = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk); #1;
         chk("midrst_no_stale", 64'(out_valid_o), 64'd0);
      end

`ifdef MUL_FLUSH_EN
      // Flush with the pipeline full and an op offered
      out_ready_i = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk); rand_op();
      end
      @(negedge clk);
      rand_op();
      flush_i = 1'b1;
      exp_res.delete();
      exp_tag.delete();
      #1;
      chk("flush_no_accept", 64'(in_ready_o), 64'd0);
      @(negedge clk);
      flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      #1;
      chk("flush_valid_low", 64'(out_valid_o), 64'd0);
      @(negedge clk);
      in_valid_i = 1'b1; a_i = 32'd1234; b_i = 32'hFFFF_FFFE;
      a_signed_i = 1'b0; b_signed_i = 1'b1; tag_i = 4'd6;
      #1;
      lat = 0;
      do begin
         @(negedge clk); in_valid_i = 1'b0; #1; lat++;
      end while (!out_valid_o && lat < 8);
      chk("flush_next_latency", 64'(lat), 64'd3);
      chk("flush_next_res", 64'(res_o), 64'hFFFF_FFFF_FFFF_F65C);
`endif

      // Random traffic with random backpressure
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         rand_op();
         in_valid_i  = ($urandom_range(0, 3) != 0);
         out_ready_i = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      for (int cyc = 0; cyc < 10 && exp_res.size() != 0; cyc++) @(negedge clk);
      #2;
      chk("final_drain_empty", 64'(exp_res.size()), 64'd0);
      chk("final_valid_low", 64'(out_valid_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
